// File: rtl/cpu_memory_pkg.sv
// Shared types and constants for the MEM stage.
package cpu_memory_pkg;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] alu;
    logic [31:0] mem_data;
    logic [1:0]  wb_mux;
  } mem_wb_t;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_port.sv
// Data-memory bus handshake: request/response FSM with load timeout.
module dmem_port
  import cpu_memory_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic access,
  input  logic is_store,
  input  logic dmem_ready,
  input  logic dmem_rvalid,
  output logic dmem_req,
  output logic stall,
  output logic done,
  output logic rdata_valid,
  output logic err
);

  localparam logic [31:0] TO = 32'(TIMEOUT);

  mem_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dmem_req    = 1'b0;
    stall       = 1'b0;
    done        = 1'b0;
    rdata_valid = 1'b0;
    err         = 1'b0;
    unique case (state_q)
      MEM_IDLE, MEM_REQ: begin
        if (access) begin
          dmem_req = 1'b1;
          if (dmem_ready) begin
            if (is_store) begin
              done    = 1'b1;
              state_d = MEM_IDLE;
            end else if (dmem_rvalid) begin
              done        = 1'b1;
              rdata_valid = 1'b1;
              state_d     = MEM_IDLE;
            end else begin
              stall   = 1'b1;
              cnt_d   = 32'd1;
              state_d = MEM_RESP;
            end
          end else begin
            stall   = 1'b1;
            state_d = MEM_REQ;
          end
        end else begin
          state_d = MEM_IDLE;
        end
      end
      MEM_RESP: begin
        stall = 1'b1;
        if (dmem_rvalid) begin
          stall       = 1'b0;
          done        = 1'b1;
          rdata_valid = 1'b1;
          cnt_d       = '0;
          state_d     = MEM_IDLE;
        end else if (TIMEOUT != 0 && cnt_q == TO) begin
          stall   = 1'b0;
          err     = 1'b1;
          cnt_d   = '0;
          state_d = MEM_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = MEM_IDLE;
      end
    endcase
    // Reset drops the bus and releases the pipeline at once.
    if (rst) begin
      dmem_req    = 1'b0;
      stall       = 1'b0;
      done        = 1'b0;
      rdata_valid = 1'b0;
      err         = 1'b0;
    end
  end

endmodule

// File: rtl/cpu_memory.sv
// MEM stage: bus access via dmem_port, forwarding path, MEM/WB register.
module cpu_memory
  import cpu_memory_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_addr,
  input  logic        reg_write,
  input  logic        mem_write,
  input  logic [1:0]  wb_mux,
  output logic [31:0] forward_mem,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  rd_addr_out,
  output logic        reg_write_out,
  output logic [31:0] wb_alu_out,
  output logic [31:0] wb_mem_data,
  output logic [1:0]  wb_mux_out,
  output logic        mem_err
);

  logic    is_load, is_store, access, mis;
  logic    done, rdata_valid, err;
  mem_wb_t wb_q, wb_d;
  logic    mem_err_q, mem_err_d;

  assign is_load  = (wb_mux == WB_MEM) && !mem_write;
  assign is_store = mem_write;
  assign access   = is_load || is_store;
  assign mis      = access && misaligned(alu_result);

  assign forward_mem = alu_result;
  assign dmem_we     = is_store;
  assign dmem_addr   = alu_result;
  assign dmem_wdata  = rs2_data;

  dmem_port #(
    .TIMEOUT(TIMEOUT)
  ) u_port (
    .clk        (clk),
    .rst        (rst),
    .access     (access && !mis),
    .is_store   (is_store),
    .dmem_ready (dmem_ready),
    .dmem_rvalid(dmem_rvalid),
    .dmem_req   (dmem_req),
    .stall      (stall),
    .done       (done),
    .rdata_valid(rdata_valid),
    .err        (err)
  );

  always_comb begin
    wb_d      = wb_q;
    mem_err_d = 1'b0;
    if (stall) begin
      wb_d.reg_write = 1'b0;
    end else begin
      wb_d.rd        = rd_addr;
      wb_d.reg_write = reg_write && !mis && !err;
      wb_d.alu       = alu_result;
      wb_d.wb_mux    = wb_mux;
      if (done && rdata_valid) begin
        wb_d.mem_data = dmem_rdata;
      end
      mem_err_d = mis || err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q      <= '0;
      mem_err_q <= 1'b0;
    end else begin
      wb_q      <= wb_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign rd_addr_out   = wb_q.rd;
  assign reg_write_out = wb_q.reg_write;
  assign wb_alu_out    = wb_q.alu;
  assign wb_mem_data   = wb_q.mem_data;
  assign wb_mux_out    = wb_q.wb_mux;
  assign mem_err       = mem_err_q;

endmodule

// File: tb/tb_cpu_memory.sv
// Scoreboard bench for cpu_memory: driver pushes expected MEM/WB, monitor pops.
module tb_cpu_memory;
  import cpu_memory_pkg::*;

  logic        clk, rst;
  logic [31:0] alu_result, rs2_data, dmem_rdata;
  logic [4:0]  rd_addr;
  logic        reg_write, mem_write, dmem_ready, dmem_rvalid;
  logic [1:0]  wb_mux;
  logic [31:0] forward_mem, dmem_addr, dmem_wdata, wb_alu_out, wb_mem_data;
  logic        stall, dmem_req, dmem_we, reg_write_out, mem_err;
  logic [4:0]  rd_addr_out;
  logic [1:0]  wb_mux_out;

  cpu_memory #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .alu_result(alu_result), .rs2_data(rs2_data),
    .rd_addr(rd_addr), .reg_write(reg_write),
    .mem_write(mem_write), .wb_mux(wb_mux),
    .forward_mem(forward_mem), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata),
    .rd_addr_out(rd_addr_out), .reg_write_out(reg_write_out),
    .wb_alu_out(wb_alu_out), .wb_mem_data(wb_mem_data),
    .wb_mux_out(wb_mux_out), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] alu;
    logic [31:0] md;
    logic [1:0]  wm;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic tb_valid;
  bit   pv, ps;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: an instruction leaves MEM on the edge after a non-stalled cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pv = 1'b0;
      ps = 1'b0;
    end else begin
      if (pv && !ps) begin
        if (exp_q.size() == 0) begin
          chk("unexpected output", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk({e.nm, " rd"}, 64'(rd_addr_out), 64'(e.rd));
          chk({e.nm, " reg_write"}, 64'(reg_write_out), 64'(e.rw));
          chk({e.nm, " wb_alu"}, 64'(wb_alu_out), 64'(e.alu));
          chk({e.nm, " wb_mem_data"}, 64'(wb_mem_data), 64'(e.md));
          chk({e.nm, " wb_mux"}, 64'(wb_mux_out), 64'(e.wm));
          chk({e.nm, " mem_err"}, 64'(mem_err), 64'(e.err));
        end
      end
      if (ps) chk("bubble reg_write", 64'(reg_write_out), 64'd0);
      pv = tb_valid;
      ps = stall;
    end
  end

  task automatic set_nop();
    alu_result  = '0;
    rs2_data    = '0;
    rd_addr     = '0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    wb_mux      = WB_ALU;
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0BAD_0BAD;
    tb_valid    = 1'b0;
  endtask

  task automatic issue(
    input string nm, input logic [31:0] a, input logic [31:0] d,
    input logic [4:0] r, input logic rw, input logic mw,
    input logic [1:0] wm, input int rdy_lat, input int rv_lat,
    input logic [31:0] rdat, input int exp_stall, input int exp_req,
    input logic exp_rw, input logic [31:0] exp_md, input logic exp_err);
    int c, nst, nrq;
    bit fin;
    exp_q.push_back('{nm, r, exp_rw, a, exp_md, wm, exp_err});
    @(posedge clk); #1;
    alu_result = a;
    rs2_data   = d;
    rd_addr    = r;
    reg_write  = rw;
    mem_write  = mw;
    wb_mux     = wm;
    tb_valid   = 1'b1;
    c = 0; nst = 0; nrq = 0; fin = 0;
    while (!fin) begin
      dmem_ready  = (c == rdy_lat);
      dmem_rvalid = (rv_lat >= 0) && (c == rdy_lat + rv_lat);
      dmem_rdata  = dmem_rvalid ? rdat : 32'h0BAD_0BAD;
      @(negedge clk);
      chk({nm, " forward"}, 64'(forward_mem), 64'(a));
      if (dmem_req) begin
        nrq++;
        chk({nm, " addr"}, 64'(dmem_addr), 64'(a));
        chk({nm, " wdata"}, 64'(dmem_wdata), 64'(d));
        chk({nm, " we"}, 64'(dmem_we), 64'(mw));
      end
      if (stall) nst++;
      else fin = 1;
      if (!fin && c > 20) begin
        chk({nm, " stall bound"}, 64'(c), 64'd20);
        fin = 1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        c++;
      end
    end
    chk({nm, " stall cycles"}, 64'(nst), 64'(exp_stall));
    chk({nm, " req cycles"}, 64'(nrq), 64'(exp_req));
    @(posedge clk); #1;
    set_nop();
  endtask

  initial begin
    rst = 1'b1;
    set_nop();
    @(negedge clk);
    chk("reset reg_write", 64'(reg_write_out), 64'd0);
    chk("reset rd", 64'(rd_addr_out), 64'd0);
    chk("reset wb_alu", 64'(wb_alu_out), 64'd0);
    chk("reset wb_mem_data", 64'(wb_mem_data), 64'd0);
    chk("reset wb_mux", 64'(wb_mux_out), 64'd0);
    chk("reset mem_err", 64'(mem_err), 64'd0);
    chk("reset dmem_req", 64'(dmem_req), 64'd0);
    chk("reset stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    issue("alu", 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, WB_ALU,
          -1, -1, 32'h0, 0, 0, 1'b1, 32'h0, 1'b0);
    issue("store wait", 32'h100, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, WB_ALU,
          2, -1, 32'h0, 2, 3, 1'b0, 32'h0, 1'b0);
    issue("load rv3", 32'h200, 32'h0, 5'd7, 1'b1, 1'b0, WB_MEM,
          0, 3, 32'hCAFE_F00D, 3, 1, 1'b1, 32'hCAFE_F00D, 1'b0);
    issue("load misaligned", 32'h203, 32'h0, 5'd6, 1'b1, 1'b0, WB_MEM,
          0, 0, 32'h1111_1111, 0, 0, 1'b0, 32'hCAFE_F00D, 1'b1);
    issue("load timeout", 32'h300, 32'h0, 5'd8, 1'b1, 1'b0, WB_MEM,
          0, -1, 32'h0, 4, 1, 1'b0, 32'hCAFE_F00D, 1'b1);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_5555;
    @(posedge clk); #1;
    set_nop();
    issue("pc4 after late rvalid", 32'h44, 32'h0, 5'd1, 1'b1, 1'b0, WB_PC4,
          -1, -1, 32'h0, 0, 0, 1'b1, 32'hCAFE_F00D, 1'b0);
    issue("load zero-wait", 32'h404, 32'h0, 5'd9, 1'b1, 1'b0, WB_MEM,
          0, 0, 32'h1111_2222, 0, 1, 1'b1, 32'h1111_2222, 1'b0);
    issue("load req+resp", 32'h408, 32'h0, 5'd10, 1'b1, 1'b0, WB_MEM,
          1, 1, 32'h8765_4321, 2, 2, 1'b1, 32'h8765_4321, 1'b0);
    issue("store zero-wait", 32'h40C, 32'h0A0B_0C0D, 5'd0, 1'b0, 1'b1, WB_ALU,
          0, -1, 32'h0, 0, 1, 1'b0, 32'h8765_4321, 1'b0);

    // Reset while a load waits in RESP.
    @(posedge clk); #1;
    alu_result = 32'h500;
    rd_addr    = 5'd11;
    reg_write  = 1'b1;
    wb_mux     = WB_MEM;
    dmem_ready = 1'b1;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    @(negedge clk);
    chk("resp stall", 64'(stall), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst dmem_req", 64'(dmem_req), 64'd0);
    chk("midrst stall", 64'(stall), 64'd0);
    chk("midrst reg_write", 64'(reg_write_out), 64'd0);
    chk("midrst rd", 64'(rd_addr_out), 64'd0);
    chk("midrst wb_alu", 64'(wb_alu_out), 64'd0);
    chk("midrst wb_mem_data", 64'(wb_mem_data), 64'd0);
    chk("midrst wb_mux", 64'(wb_mux_out), 64'd0);
    chk("midrst mem_err", 64'(mem_err), 64'd0);
    @(posedge clk); #1;
    set_nop();
    rst = 1'b0;

    issue("alu after reset", 32'h99, 32'h0, 5'd3, 1'b1, 1'b0, WB_ALU,
          -1, -1, 32'h0, 0, 0, 1'b1, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
